// File: rtl/emu_run_ctrl_pkg.sv
// run_ctrl_package: types and defaults for the emulator run controller.
//   RUN_STATE     - controller state, binary encoded (IDLE=0, WARMUP=1, MEASURE=2, DONE=3).
//   RUN_CNT_WIDTH - default width of the per-lane bit and error counters.
package run_ctrl_package;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } RUN_STATE;

    localparam int unsigned RUN_CNT_WIDTH = 32;

endpackage

// File: rtl/time_package.sv
// time_package: shared emulated-time type used by the time manager and its consumers.
//   TIME_FORMAT - unsigned emulated time value, compared at full width.
package time_package;

    typedef logic [63:0] TIME_FORMAT;

endpackage

// File: rtl/emu_run_ctrl_if.sv
// emu_run_ctrl_if: run-controller signal bundle.
//   Inputs to the controller: time_curr, time_start, time_stop, cke_lane, bit_valid, bit_err.
//   Outputs from it: rst_core, rst_lane, run_state, bit_count, err_count, sim_done.
//   bit_count / err_count pack lane i into bits [i*CNT_WIDTH +: CNT_WIDTH].
//   master: the environment (time manager, checkers, top level); slave: emu_run_ctrl.
interface emu_run_ctrl_if import time_package::*, run_ctrl_package::*; #(
    parameter int unsigned N_LANES   = 2,
    parameter int unsigned CNT_WIDTH = RUN_CNT_WIDTH
) ();

    TIME_FORMAT                   time_curr;
    TIME_FORMAT                   time_start;
    TIME_FORMAT                   time_stop;
    logic [N_LANES-1:0]           cke_lane;
    logic [N_LANES-1:0]           bit_valid;
    logic [N_LANES-1:0]           bit_err;
    logic                         rst_core;
    logic [N_LANES-1:0]           rst_lane;
    RUN_STATE                     run_state;
    logic [N_LANES*CNT_WIDTH-1:0] bit_count;
    logic [N_LANES*CNT_WIDTH-1:0] err_count;
    logic                         sim_done;

    modport master (
        output time_curr, time_start, time_stop, cke_lane, bit_valid, bit_err,
        input  rst_core, rst_lane, run_state, bit_count, err_count, sim_done
    );

    modport slave (
        input  time_curr, time_start, time_stop, cke_lane, bit_valid, bit_err,
        output rst_core, rst_lane, run_state, bit_count, err_count, sim_done
    );

endinterface

// File: rtl/emu_run_ctrl_sat_counter.sv
// sat_counter: unsigned up-counter that sticks at all-ones instead of wrapping.
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - increment request for this cycle
//   count - registered count value
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/emu_run_ctrl.sv
// emu_run_ctrl: run controller for the link emulator.
//   Sequences the core reset and per-lane clock-enable-aligned resets, holds off counting
//   during warm-up, counts checked bits and errors per lane during the measurement window
//   and raises a sticky sim_done at the end of the run.
// Ports:
//   clk  - system emulation clock
//   rst  - synchronous active-high reset (returns to IDLE from any state)
//   ctrl - emu_run_ctrl_if.slave: time inputs, lane strobes, resets, state, counters, done
// Configuration:
//   EMU_RUN_ERR_LIMIT_EN - when defined, any lane reaching ERR_LIMIT errors ends MEASURE.
module emu_run_ctrl import run_ctrl_package::*; #(
    parameter int unsigned N_LANES   = 2,
    parameter int unsigned CNT_WIDTH = RUN_CNT_WIDTH,
    parameter int unsigned ERR_LIMIT = 16
) (
    input logic          clk,
    input logic          rst,
    emu_run_ctrl_if.slave ctrl
);

`ifdef EMU_RUN_ERR_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    RUN_STATE                           state_q, state_d;
    logic                               rst_core_q;
    logic [N_LANES-1:0]                 rst_lane_q;
    logic                               sim_done_q;
    logic [N_LANES-1:0]                 bit_inc, err_inc;
    logic [N_LANES-1:0][CNT_WIDTH-1:0]  bit_cnt, err_cnt;
    logic                               stop_hit, start_hit, err_hit;

    assign stop_hit  = ctrl.time_curr >= ctrl.time_stop;
    assign start_hit = ctrl.time_curr >= ctrl.time_start;

    // Early stop looks at the registered error counts; folds to 0 when the limit is disabled.
    always_comb begin
        err_hit = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (LIMIT_EN && (64'(err_cnt[i]) >= 64'(ERR_LIMIT))) begin
                err_hit = 1'b1;
            end
        end
    end

    // Stop is tested before start so a stop threshold at or below start skips MEASURE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = WARMUP;
            WARMUP: begin
                if (stop_hit) begin
                    state_d = DONE;
                end else if (start_hit) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (stop_hit || err_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_core_q <= 1'b1;
            rst_lane_q <= '1;
            sim_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_core_q <= 1'b0;
            // Each lane leaves reset on its own first clock enable and never re-enters.
            rst_lane_q <= rst_lane_q & ~ctrl.cke_lane;
            sim_done_q <= (state_d == DONE);
        end
    end

    // Gated on the registered state, so the WARMUP->MEASURE edge does not count and the
    // MEASURE->DONE edge does.
    assign bit_inc = {N_LANES{state_q == MEASURE}} & ~rst_lane_q & ctrl.bit_valid;
    assign err_inc = bit_inc & ctrl.bit_err;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_bit_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (bit_inc[i]),
            .count (bit_cnt[i])
        );

        sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_err_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (err_inc[i]),
            .count (err_cnt[i])
        );
    end

    assign ctrl.run_state = state_q;
    assign ctrl.rst_core  = rst_core_q;
    assign ctrl.rst_lane  = rst_lane_q;
    assign ctrl.sim_done  = sim_done_q;
    assign ctrl.bit_count = bit_cnt;
    assign ctrl.err_count = err_cnt;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// tb_emu_run_ctrl: self-checking bench for emu_run_ctrl (2 lanes, 4-bit counters, limit 3).
//   A behavioural model tracks phase, resets and counts from the run rules; each scenario
//   task compares the DUT against it every cycle plus a few fixed expectations.
module tb_emu_run_ctrl;
    import time_package::*;

    localparam int unsigned NL = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned EL = 3;
    localparam int CMAX = 15;

`ifdef EMU_RUN_ERR_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    localparam logic [21:0] RESET_VEC = {2'd0, 1'b1, 2'b11, 1'b0, 16'h0000};

    logic clk = 1'b0;
    logic rst = 1'b1;

    emu_run_ctrl_if #(.N_LANES(NL), .CNT_WIDTH(CW)) bus ();

    emu_run_ctrl #(
        .N_LANES   (NL),
        .CNT_WIDTH (CW),
        .ERR_LIMIT (EL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: phase 0..3 = idle, warm-up, measuring, done.
    int       m_phase;
    bit       m_core;
    bit [1:0] m_lane;
    int       m_bits[2];
    int       m_errs[2];

    task automatic tick();
        bit stop_now, start_now, limit;
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_core  = 1'b1;
            m_lane  = 2'b11;
            m_bits  = '{0, 0};
            m_errs  = '{0, 0};
        end else begin
            stop_now  = bus.time_curr >= bus.time_stop;
            start_now = bus.time_curr >= bus.time_start;
            limit = 1'b0;
            for (int i = 0; i < 2; i++) if (m_errs[i] >= int'(EL)) limit = 1'b1;
            if (m_phase == 2) begin
                for (int i = 0; i < 2; i++) begin
                    if (!m_lane[i] && bus.bit_valid[i]) begin
                        if (m_bits[i] < CMAX) m_bits[i]++;
                        if (bus.bit_err[i] && m_errs[i] < CMAX) m_errs[i]++;
                    end
                end
            end
            for (int i = 0; i < 2; i++) if (bus.cke_lane[i]) m_lane[i] = 1'b0;
            m_core = 1'b0;
            case (m_phase)
                0: m_phase = 1;
                1: m_phase = stop_now ? 3 : (start_now ? 2 : 1);
                2: if (stop_now || (LIMIT_ON && limit)) m_phase = 3;
                default: m_phase = 3;
            endcase
        end
        #1;
    endtask

    function automatic logic [21:0] exp_vec();
        return {2'(m_phase), m_core, m_lane, 1'(m_phase == 3),
                4'(m_bits[1]), 4'(m_bits[0]), 4'(m_errs[1]), 4'(m_errs[0])};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus.run_state, bus.rst_core, bus.rst_lane, bus.sim_done,
                bus.bit_count, bus.err_count};
    endfunction

    task automatic set_lanes(input logic [1:0] cke, input logic [1:0] vld,
                             input logic [1:0] err);
        bus.cke_lane  = cke;
        bus.bit_valid = vld;
        bus.bit_err   = err;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        set_lanes(2'b00, 2'b00, 2'b00);
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.time_curr = 64'd0;
        bus.time_start = 64'd100;
        bus.time_stop = 64'd200;
        for (int c = 0; c < 5; c++) begin
            set_lanes(2'($urandom), 2'($urandom), 2'($urandom));
            tick();
            checks++;
            if (dut_vec() !== RESET_VEC) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", c, dut_vec(), RESET_VEC);
            end
        end
    endtask

    task automatic test_lane_resets();
        logic [1:0] exp_lane;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            set_lanes((k == 3) ? 2'b10 : ((k == 7) ? 2'b01 : 2'b00), 2'($urandom), 2'b00);
            tick();
            exp_lane = {1'(k < 3), 1'(k < 7)};
            checks++;
            if (bus.rst_lane !== exp_lane || bus.rst_core !== 1'b0) begin
                failures++;
                $display("FAIL lane_resets k=%0d got lane=%b core=%b exp lane=%b core=0",
                         k, bus.rst_lane, bus.rst_core, exp_lane);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL lane_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_window();
        apply_reset(2);
        bus.time_start = 64'd100;
        bus.time_stop = 64'd200;
        for (int c = 0; c < 30; c++) begin
            bus.time_curr = 64'(10 * c);
            set_lanes((c == 0) ? 2'b11 : 2'b00, 2'b11, 2'b00);
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || bus.sim_done !== 1'(c >= 20)) begin
                failures++;
                $display("FAIL window cyc=%0d got=%h exp=%h done_exp=%0d",
                         c, dut_vec(), exp_vec(), (c >= 20));
            end
        end
        checks++;
        if (bus.bit_count !== 8'hAA || bus.run_state !== 2'd3) begin
            failures++;
            $display("FAIL window_total got bits=%h state=%0d exp bits=aa state=3",
                     bus.bit_count, bus.run_state);
        end
    endtask

    task automatic test_stop_before_start();
        apply_reset(2);
        bus.time_start = 64'd200;
        bus.time_stop = 64'd100;
        for (int c = 0; c < 20; c++) begin
            bus.time_curr = 64'(10 * c);
            set_lanes((c == 0) ? 2'b11 : 2'b00, 2'b11, 2'($urandom));
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || bus.run_state === 2'd2
                || bus.sim_done !== 1'(c >= 10)) begin
                failures++;
                $display("FAIL stop_first cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.bit_count !== 8'h00 || bus.err_count !== 8'h00) begin
            failures++;
            $display("FAIL stop_first_counts got bits=%h errs=%h exp 00/00",
                     bus.bit_count, bus.err_count);
        end
    endtask

    task automatic test_saturation();
        apply_reset(2);
        bus.time_start = 64'd10;
        bus.time_stop = 64'd1000;
        for (int c = 0; c < 25; c++) begin
            bus.time_curr = 64'(10 * c);
            set_lanes((c == 0) ? 2'b11 : 2'b00, 2'b10, {1'b1, 1'($urandom)});
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL saturation cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
`ifndef EMU_RUN_ERR_LIMIT_EN
        checks++;
        if (bus.err_count !== 8'hF0 || bus.bit_count !== 8'hF0) begin
            failures++;
            $display("FAIL saturation_total got errs=%h bits=%h exp errs=f0 bits=f0",
                     bus.err_count, bus.bit_count);
        end
`endif
    endtask

    task automatic test_err_limit();
        apply_reset(2);
        bus.time_start = 64'd10;
        bus.time_stop = 64'd1000;
        for (int c = 0; c < 15; c++) begin
            bus.time_curr = 64'(10 * c);
            // Errors on lane 0 land on the first three counted edges (c = 2, 3, 4).
            set_lanes((c == 0) ? 2'b11 : 2'b00, 2'b01, {1'b0, 1'(c >= 2 && c <= 4)});
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL err_limit cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.run_state !== (LIMIT_ON ? 2'd3 : 2'd2)) begin
            failures++;
            $display("FAIL err_limit_state got=%0d exp=%0d", bus.run_state,
                     LIMIT_ON ? 3 : 2);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(2);
        bus.time_start = 64'd10;
        bus.time_stop = 64'd1000;
        for (int c = 0; c < 8; c++) begin
            bus.time_curr = 64'(10 * c);
            set_lanes(2'b11, 2'b11, 2'b00);
            tick();
        end
        checks++;
        if (dut_vec() !== exp_vec() || bus.run_state !== 2'd2) begin
            failures++;
            $display("FAIL mid_pre got=%h exp=%h", dut_vec(), exp_vec());
        end
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", dut_vec(), RESET_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        longint unsigned t;
        for (int run = 0; run < 4; run++) begin
            apply_reset(2);
            t = 0;
            bus.time_start = 64'($urandom_range(0, 400));
            bus.time_stop = 64'($urandom_range(0, 500));
            for (int c = 0; c < 120; c++) begin
                bus.time_curr = t;
                rst = ($urandom_range(0, 49) == 0);
                set_lanes(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                          2'($urandom), 2'($urandom));
                tick();
                t += longint'($urandom_range(0, 15));
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random run=%0d cyc=%0d got=%h exp=%h",
                             run, c, dut_vec(), exp_vec());
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        set_lanes(2'b00, 2'b00, 2'b00);
        test_reset();
        test_lane_resets();
        test_window();
        test_stop_before_start();
        test_saturation();
        test_err_limit();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
